imem_fetch_responder: RTL and testbench
=======================================

// Module: imem_fetch_responder
// PURPOSE
//  Instruction-memory side of the fetch interface: takes the fetch addresses produced by program_counter
//  (pc_out) as valid/ready requests and returns 32-bit instruction words in request order.
//  Word-addressed synchronous ROM plus a response FIFO so the fetch stage can stall without losing data.
//  Flush port discards all outstanding fetches on a jump/branch redirect.
// PARAMETERS
//  ADDR_W     32   request address width (byte address)
//  DATA_W     32   instruction width
//  MEM_WORDS  256  ROM depth in 32-bit words; word index = req_addr[ADDR_W-1:2]
//  RSP_DEPTH  2    response FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1       clock; all state changes on rising edge
//  reset      in   1       synchronous, active-low reset (0 = reset)
//  req_valid  in   1       fetch address valid
//  req_ready  out  1       responder can accept a request this cycle
//  req_addr   in   ADDR_W  fetch byte address (from pc_out)
//  flush      in   1       redirect: discard in-flight and queued responses
//  rsp_valid  out  1       rsp_* hold a valid response
//  rsp_ready  in   1       consumer takes the response this cycle
//  rsp_instr  out  DATA_W  instruction word (NOP on fault)
//  rsp_addr   out  ADDR_W  address the response belongs to
//  rsp_fault  out  1       misaligned or out-of-range request
//  ld_en      in   1       program-load write enable
//  ld_addr    in   clog2(MEM_WORDS)  load word index
//  ld_data    in   DATA_W  load data
// BEHAVIOUR
//  - Reset (reset==0 at edge): FIFO empty, read stage invalid; req_ready=0 during reset, rsp_valid=0,
//    rsp_instr/rsp_addr=0, rsp_fault=0. ROM contents not cleared.
//  - Accept: req_valid && req_ready at edge N. Read stage registers addr, fault, ROM word; pushes into FIFO at N+1.
//    rsp_valid earliest in cycle N+1 (1-cycle latency, registered outputs, no comb path req->rsp).
//  - req_ready = reset && !flush && (fifo_count + rd_stage_valid) < RSP_DEPTH; Deps on state only, never on req_valid.
//  - Back-to-back: with rsp_ready held 1, one request per cycle sustained, one response per cycle.
//  - Pop: rsp_valid && rsp_ready at edge; head advances. Simultaneous push+pop on full FIFO legal; count unchanged.
//  - rsp_* stable while rsp_valid && !rsp_ready (no change until pop or flush).
//  - Fault: req_addr[1:0]!=0 or word index >= MEM_WORDS -> rsp_fault=1, rsp_instr=NOP (32'h0000_0013),
//    rsp_addr=req_addr. Fault responses occupy a FIFO slot and obey the handshake like any other.
//  - Flush at edge N: read stage invalidated, FIFO emptied (pointers/count reset); rsp_valid=0 from N+1.
//    req_ready=0 in the flush cycle, so no request is accepted with flush; a pop in the flush cycle is discarded too.
//    Accepts resume at N+1.
//  - ld_en: mem[ld_addr]<=ld_data at edge. Read of same word in same cycle returns OLD data (read-before-write).
//  - FIFO pointers wrap modulo RSP_DEPTH; count width clog2(RSP_DEPTH)+1; never exceeds RSP_DEPTH.
//  - Reset mid-operation: same as flush plus output clear; any in-flight request lost, no response issued.
// STRUCTURE
//  - Shared package riscv_pkg: XLEN=32, INSTR_NOP=32'h0000_0013, fetch response struct
//    {instr, addr, fault} typedef fetch_rsp_t.
//  - Sub-module fetch_rsp_fifo (RSP_DEPTH x fetch_rsp_t, sync active-low reset, clear input for flush).
//  - Top holds ROM array, read-stage register, fault check, req_ready logic.
// TESTING
//  1. Preload mem[0..3]=A0,A1,A2,A3; req 0x0,0x4,0x8,0xC back-to-back, rsp_ready=1 -> 4 responses
//     cycles 1..4 in order, addr matches, fault=0.
//  2. Fill: rsp_ready=0, issue reqs 0x0,0x4,0x8 -> first two accepted, req_ready=0 after; rsp held at A0;
//     raise rsp_ready -> A0 then A1, third req accepted once slot frees.
//  3. Faults: req 0x2 -> fault=1, instr=0x00000013; req 0x400 with MEM_WORDS=256 -> fault=1, addr=0x400.
//  4. Flush: two responses queued, pulse flush with req_valid=1 -> req not accepted, rsp_valid=0 next cycle;
//     req 0x8 after -> only A2 returned.
//  5. Reset mid-stream: reset=0 for 1 cycle with 2 queued -> rsp_valid=0, outputs 0, ROM still holds A0..A3.
//  6. Load collision: ld_en writes mem[1]=B1 same cycle as req 0x4 -> rsp A1; next req 0x4 -> B1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: machine width, canonical NOP and the response record
// carried from the instruction memory back to the fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] addr;
        logic            fault;
    } fetch_rsp_t;

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Response queue between the ROM read stage and the fetch stage; clear_i empties it in one
// cycle on a redirect.
module fetch_rsp_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            push_i,
    input  fetch_rsp_t      push_data_i,
    input  logic            pop_i,
    output fetch_rsp_t      head_o,
    output logic [CntW-1:0] count_o
);

    fetch_rsp_t      mem_q [Depth];
    fetch_rsp_t      mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: word-addressed ROM with a one-cycle read stage feeding an
// in-order response FIFO; the read stage is presented directly when the FIFO is empty.
module imem_fetch_responder
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic                         flush,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_instr,
    output logic [ADDR_W-1:0]            rsp_addr,
    output logic                         rsp_fault,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [DATA_W-1:0]            ld_data
);

    localparam int unsigned MemAw = $clog2(MEM_WORDS);
    localparam int unsigned CntW  = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned OccW  = CntW + 1;

    logic [DATA_W-1:0] rom [MEM_WORDS];
    logic [ADDR_W-3:0] word_full;
    logic [MemAw-1:0]  word_idx;
    logic              addr_fault;
    logic [OccW-1:0]   occupancy;
    logic              accept;
    logic              rsp_pop;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CntW-1:0]   fifo_count;
    logic              rd_valid_q, rd_valid_d;
    fetch_rsp_t        rd_rsp_q, rd_rsp_d;
    fetch_rsp_t        fifo_head;
    fetch_rsp_t        rsp_sel;

    // ROM contents survive reset; the non-blocking write gives read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            rom[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        word_full  = req_addr[ADDR_W-1:2];
        word_idx   = req_addr[MemAw+1:2];
        addr_fault = (req_addr[1:0] != 2'b00) || ({2'b00, word_full} >= ADDR_W'(MEM_WORDS));
    end

    // Read stage plus FIFO together never hold more than RSP_DEPTH responses.
    always_comb begin
        occupancy  = OccW'(fifo_count) + OccW'(rd_valid_q);
        req_ready  = reset && !flush && (occupancy < OccW'(RSP_DEPTH));
        accept     = req_valid && req_ready;
        fifo_empty = (fifo_count == '0);
        rsp_valid  = !fifo_empty || rd_valid_q;
        rsp_sel    = fifo_empty ? rd_rsp_q : fifo_head;
        rsp_pop    = rsp_valid && rsp_ready;
        fifo_pop   = rsp_pop && !fifo_empty;
        fifo_push  = rd_valid_q && !(rsp_pop && fifo_empty);
    end

    always_comb begin
        rd_valid_d = accept;
        rd_rsp_d   = rd_rsp_q;
        if (accept) begin
            rd_rsp_d.fault = addr_fault;
            rd_rsp_d.addr  = XLEN'(req_addr);
            rd_rsp_d.instr = addr_fault ? INSTR_NOP : XLEN'(rom[word_idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            rd_rsp_q   <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_rsp_q   <= rd_rsp_d;
        end
    end

    fetch_rsp_fifo #(
        .Depth(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clear_i    (flush),
        .push_i     (fifo_push),
        .push_data_i(rd_rsp_q),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count)
    );

    always_comb begin
        rsp_instr = '0;
        rsp_addr  = '0;
        rsp_fault = 1'b0;
        if (rsp_valid) begin
            rsp_instr = DATA_W'(rsp_sel.instr);
            rsp_addr  = ADDR_W'(rsp_sel.addr);
            rsp_fault = rsp_sel.fault;
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based model of outstanding fetches.
module tb_imem_fetch_responder;

    localparam int unsigned MEM_WORDS = 256;
    localparam int unsigned RSP_DEPTH = 2;
    localparam logic [31:0] A0  = 32'h1000_00A0;
    localparam logic [31:0] A1  = 32'h1000_00A1;
    localparam logic [31:0] A2  = 32'h1000_00A2;
    localparam logic [31:0] A3  = 32'h1000_00A3;
    localparam logic [31:0] B1  = 32'hB1B1_B1B1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, flush, rsp_valid, rsp_ready, rsp_fault, ld_en;
    logic [31:0] req_addr, rsp_instr, rsp_addr, ld_data;
    logic [7:0]  ld_addr;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        fault;
    } exp_t;

    exp_t        mq[$];
    logic [31:0] mdl_mem [MEM_WORDS];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        chk_en   = 1'b0;

    always #5 clk = ~clk;

    imem_fetch_responder #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MEM_WORDS(MEM_WORDS),
        .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .flush    (flush),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_addr (rsp_addr),
        .rsp_fault(rsp_fault),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_fetch(input logic [31:0] a);
        exp_t e;
        e.addr  = a;
        e.fault = ((a % 4) != 0) || ((a / 4) >= MEM_WORDS);
        e.instr = e.fault ? NOP : mdl_mem[(a / 4) % MEM_WORDS];
        return e;
    endfunction

    // Model: every accepted, not yet consumed fetch is visible in order from the next cycle.
    always @(posedge clk) begin
        if (!reset || flush) begin
            mq.delete();
        end else begin
            bit can_accept;
            can_accept = mq.size() < RSP_DEPTH;
            if (mq.size() > 0 && rsp_ready) void'(mq.pop_front());
            if (req_valid && can_accept) mq.push_back(model_fetch(req_addr));
        end
        if (ld_en) mdl_mem[ld_addr] = ld_data;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(reset && !flush && (mq.size() < RSP_DEPTH)));
            check("rsp_valid", 32'(rsp_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                check("rsp_instr", rsp_instr, mq[0].instr);
                check("rsp_addr", rsp_addr, mq[0].addr);
                check("rsp_fault", 32'(rsp_fault), 32'(mq[0].fault));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        // Program load under reset: random image, then the known words 0..3.
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            ld_en = 1'b1; ld_addr = 8'(i); ld_data = $urandom;
            tick();
            chk_en = 1'b1;
        end
        ld_addr = 8'd0; ld_data = A0; tick();
        ld_addr = 8'd1; ld_data = A1; tick();
        ld_addr = 8'd2; ld_data = A2; tick();
        ld_addr = 8'd3; ld_data = A3; tick();
        ld_en = 1'b0;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_instr", rsp_instr, 32'd0);
        check("reset_rsp_addr", rsp_addr, 32'd0);
        check("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        reset = 1'b1;
        tick();

        // Back-to-back streaming.
        rsp_ready = 1'b1;
        req(32'h0); check("b2b_0", rsp_instr, A0);
        req(32'h4); check("b2b_1", rsp_instr, A1);
        req(32'h8); check("b2b_2", rsp_instr, A2);
        req(32'hC); check("b2b_3", rsp_instr, A3); check("b2b_3_addr", rsp_addr, 32'hC);
        req_valid = 1'b0; tick();

        // Fill with consumer stalled.
        rsp_ready = 1'b0;
        req(32'h0);
        req(32'h4);
        req_addr = 32'h8;
        check("fill_ready", 32'(req_ready), 32'd0);
        tick(); check("fill_hold", rsp_instr, A0);
        rsp_ready = 1'b1;
        tick(); check("fill_pop0", rsp_instr, A1);
        tick(); check("fill_pop1", rsp_instr, A2);
        req_valid = 1'b0; tick();

        // Faults.
        req(32'h2);
        check("mis_fault", 32'(rsp_fault), 32'd1); check("mis_instr", rsp_instr, NOP);
        req(32'h400);
        check("oor_fault", 32'(rsp_fault), 32'd1); check("oor_addr", rsp_addr, 32'h400);
        req_valid = 1'b0; tick();

        // Flush with two queued and a request pending.
        rsp_ready = 1'b0;
        req(32'h0);
        req(32'h4);
        flush = 1'b1; req_addr = 32'hC; #1;
        check("flush_ready", 32'(req_ready), 32'd0);
        tick(); check("flush_valid", 32'(rsp_valid), 32'd0);
        flush = 1'b0;
        req(32'h8);
        req_valid = 1'b0; check("flush_after", rsp_instr, A2);
        rsp_ready = 1'b1;
        tick(); check("flush_drained", 32'(rsp_valid), 32'd0);

        // Reset mid-stream.
        rsp_ready = 1'b0;
        req(32'h0);
        req(32'h4);
        req_valid = 1'b0; reset = 1'b0;
        tick();
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_instr", rsp_instr, 32'd0);
        check("rst_addr", rsp_addr, 32'd0);
        reset = 1'b1; rsp_ready = 1'b1;
        req(32'h0); check("rst_rom_kept", rsp_instr, A0);

        // Load collision: same-cycle read returns the old word.
        ld_en = 1'b1; ld_addr = 8'd1; ld_data = B1;
        req(32'h4); check("ld_old", rsp_instr, A1);
        ld_en = 1'b0;
        req(32'h4); check("ld_new", rsp_instr, B1);
        req_valid = 1'b0; tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            a = {22'd0, 8'($urandom_range(0, 299)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) a[31] = 1'b1;
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = a;
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 99) != 0);
            ld_en     = ($urandom_range(0, 9) == 0);
            ld_addr   = 8'($urandom_range(0, 255));
            ld_data   = $urandom;
            tick();
        end

        req_valid = 1'b0; flush = 1'b0; reset = 1'b1; rsp_ready = 1'b1; ld_en = 1'b0;
        repeat (4) tick();
        check("drain_empty", 32'(rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
